comb_bist_ctrl: RTL and testbench
=================================

// Module: comb_bist_ctrl
// PURPOSE
//   Exhaustive-stimulus BIST sequencer for the small combinational benchmark
//   circuits in this codebase (N_IN inputs, N_OUT outputs).
//   On start it drives every input vector 0..2^N_IN-1 into the circuit.
//   It waits SETTLE_CYC cycles per vector and folds each output word into a
//   16-bit MISR signature.
//   At the end it compares the signature with golden_sig and reports pass/fail.
// PARAMETERS
//   N_IN       4       circuit input width (1..16)
//   N_OUT      5       circuit output width (1..16)
//   SETTLE_CYC 1       wait cycles after each vector change before capture (>=1)
//   SIG_SEED   16'hFFFF  MISR value loaded when start is accepted
//   SIG_POLY   16'h1021  MISR feedback taps (x^16+x^12+x^5+1)
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      begin sweep; sampled only in IDLE
//   abort       in   1      cancel sweep; return to IDLE
//   golden_sig  in   16     expected final signature, sampled in CAPTURE of last vector
//   dut_x       out  N_IN   stimulus vector to circuit inputs
//   dut_f       in   N_OUT  circuit outputs
//   busy        out  1      high in SETTLE/CAPTURE
//   done        out  1      one-cycle pulse when sweep completes
//   pass        out  1      sweep completed and signature == golden_sig
//   fail        out  1      sweep completed and signature != golden_sig
//   signature   out  16     current MISR contents
//   vec_count   out  N_IN+1 number of vectors captured so far in this sweep
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, dut_x=0, busy=0, done=0, pass=0,
//     fail=0, signature=0, vec_count=0, settle counter=0.
//   FSM states: IDLE, SETTLE, CAPTURE.
//   IDLE
//     start=1 -> SETTLE; dut_x=0; signature=SIG_SEED; vec_count=0;
//       pass=fail=0; cnt=SETTLE_CYC-1.
//     Otherwise hold; pass/fail keep their last result.
//   SETTLE
//     cnt==0 -> CAPTURE, else cnt--.
//     dut_x stays stable throughout.
//   CAPTURE (1 cycle)
//     sig <= {sig[14:0],1'b0} ^ (sig[15] ? SIG_POLY : 0) ^ zero-extended dut_f.
//     vec_count++.
//     If dut_x != all-ones: dut_x++; cnt=SETTLE_CYC-1; -> SETTLE.
//     If dut_x == all-ones: -> IDLE; done=1 for exactly this next cycle.
//       Compare uses the updated signature:
//       pass=(sig_next==golden_sig), fail=~pass.
//       dut_x stays all-ones until the next start.
//   Latency: the done pulse asserts 2^N_IN*(SETTLE_CYC+1) cycles after the
//     start-accept edge.
//   busy = (state!=IDLE). It deasserts in the same cycle that done asserts.
//   start while busy: ignored.
//   start on the same cycle as the done pulse: accepted (state is already
//     IDLE).
//   abort (any state, priority over start and capture): -> IDLE; dut_x=0;
//     pass=fail=0; no done pulse.
//     signature and vec_count hold their values for debug.
//   Reset asserted mid-sweep: immediate return to reset values; no done pulse.
//   pass and fail are never both 1.
//   vec_count ends at 2^N_IN (needs N_IN+1 bits, so it does not wrap).
// TESTING
//   1. N_IN=4, SETTLE_CYC=1, start pulse -> dut_x walks 0..15, each held
//      2 cycles; done at cycle 32; vec_count=16.
//   2. dut_f tied 0, golden_sig = bench MISR model of 16 zero words from
//      16'hFFFF -> pass=1, fail=0.
//   3. dut_f = benchmark circuit model, golden_sig off by one bit -> fail=1,
//      pass=0; signature equals the model's value.
//   4. abort at cycle 10 -> busy=0 next cycle; no done; pass=fail=0;
//      dut_x=0; restart gives a full 32-cycle sweep.
//   5. start held high continuously -> back-to-back sweeps; done pulses at
//      cycles 32, 65, ... (1 IDLE cycle between sweeps).
//   6. rst_n low at cycle 20 -> all outputs 0 asynchronously; no done pulse;
//      SETTLE_CYC=3 sweep gives done at cycle 64.

Source files
------------

// File: rtl/comb_bist_ctrl_if.sv
// Bus bundle between the BIST sequencer and its host.
// The host side also loops the circuit outputs back in on dut_f.
interface comb_bist_ctrl_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 5
);
  logic              start;
  logic              abort;
  logic [15:0]       golden_sig;
  logic [N_IN-1:0]   dut_x;
  logic [N_OUT-1:0]  dut_f;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic [15:0]       signature;
  logic [N_IN:0]     vec_count;

  modport master (
    output start, abort, golden_sig, dut_f,
    input  dut_x, busy, done, pass, fail, signature, vec_count
  );

  modport slave (
    input  start, abort, golden_sig, dut_f,
    output dut_x, busy, done, pass, fail, signature, vec_count
  );
endinterface

// File: rtl/comb_bist_ctrl.sv
// Exhaustive-stimulus BIST sequencer: sweeps every input vector of a small
// combinational circuit, folds the responses into a 16-bit MISR, checks it.
module comb_bist_ctrl #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned N_OUT      = 5,
  parameter int unsigned SETTLE_CYC = 1,
  parameter logic [15:0] SIG_SEED   = 16'hFFFF,
  parameter logic [15:0] SIG_POLY   = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  comb_bist_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned VC_W  = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  X_ONE    = N_IN'(1);
  localparam logic [VC_W-1:0]  VC_ONE   = VC_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_IN-1:0]   x_q;
  logic [15:0]       sig_q;
  logic [VC_W-1:0]   vc_q;
  logic              done_q, pass_q, fail_q;
  logic [15:0]       f_ext;
  logic [15:0]       sig_next;
  logic              last_vec;

  always_comb begin
    f_ext = '0;
    f_ext[N_OUT-1:0] = bus.dut_f;
  end

  assign sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000) ^ f_ext;
  assign last_vec = (x_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start) state_d = SETTLE;
        SETTLE:  if (cnt_q == '0) state_d = CAPTURE;
        CAPTURE: state_d = last_vec ? IDLE : SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Abort leaves signature and vec_count untouched so a cancelled sweep can be inspected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      x_q    <= '0;
      sig_q  <= '0;
      vc_q   <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        x_q    <= '0;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              x_q    <= '0;
              sig_q  <= SIG_SEED;
              vc_q   <= '0;
              pass_q <= 1'b0;
              fail_q <= 1'b0;
              cnt_q  <= CNT_LOAD;
            end
          end
          SETTLE: begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          end
          CAPTURE: begin
            sig_q <= sig_next;
            vc_q  <= vc_q + VC_ONE;
            if (!last_vec) begin
              x_q   <= x_q + X_ONE;
              cnt_q <= CNT_LOAD;
            end else begin
              done_q <= 1'b1;
              pass_q <= (sig_next == bus.golden_sig);
              fail_q <= (sig_next != bus.golden_sig);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.dut_x     = x_q;
    bus.done      = done_q;
    bus.pass      = pass_q;
    bus.fail      = fail_q;
    bus.signature = sig_q;
    bus.vec_count = vc_q;
  end

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Bench for comb_bist_ctrl: table-driven sweeps, randomized response tables,
// abort / back-to-back / mid-sweep reset sequences, against a MISR model.
module tb_comb_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comb_bist_ctrl_if #(.N_IN(4), .N_OUT(5)) bus0 ();
  comb_bist_ctrl_if #(.N_IN(4), .N_OUT(5)) bus1 ();

  comb_bist_ctrl #(.N_IN(4), .N_OUT(5), .SETTLE_CYC(1),
                   .SIG_SEED(16'hFFFF), .SIG_POLY(16'h1021))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  comb_bist_ctrl #(.N_IN(4), .N_OUT(5), .SETTLE_CYC(3),
                   .SIG_SEED(16'hFFFF), .SIG_POLY(16'h1021))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [4:0] lut0 [16];
  logic [4:0] lut1 [16];
  assign bus0.dut_f = lut0[bus0.dut_x];
  assign bus1.dut_f = lut1[bus1.dut_x];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Benchmark circuit: a small arithmetic function of the 4-bit input.
  function automatic logic [4:0] circ(input int x);
    int r;
    r = (x * 7 + 3) ^ (x >> 1);
    return r[4:0];
  endfunction

  // MISR as polynomial arithmetic: double, reduce mod x^16+x^12+x^5+1, add word.
  function automatic logic [15:0] model_sig(input logic [4:0] tbl [16], input int count);
    int s;
    s = 'hFFFF;
    for (int v = 0; v < count; v++) begin
      s = s * 2;
      if (s >= 'h10000) s = s ^ 'h11021;
      s = s ^ int'(tbl[v]);
    end
    return s[15:0];
  endfunction

  // Runs one sweep on u0 starting #1 after a clock edge; checks walk, latency, result.
  task automatic run_sweep(input string tag, input logic [15:0] golden,
                           input logic [15:0] exp_sig, input logic exp_pass);
    int n;
    int walk_err;
    bit got;
    n = 0; walk_err = 0; got = 0;
    bus0.golden_sig = golden;
    bus0.start = 1'b1;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) bus0.start = 1'b0;
      if (bus0.done) got = 1;
      else begin
        if (int'(bus0.dut_x) != (n - 1) / 2) walk_err++;
        if (int'(bus0.vec_count) != (n - 1) / 2) walk_err++;
        if (bus0.busy !== 1'b1) walk_err++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, n - 1, 32'd32);
    check({tag, "_walk"}, walk_err, 32'd0);
    check({tag, "_sig"}, bus0.signature, exp_sig);
    check({tag, "_pass"}, bus0.pass, exp_pass);
    check({tag, "_fail"}, bus0.fail, !exp_pass);
    check({tag, "_vec_count"}, bus0.vec_count, 32'd16);
    check({tag, "_x_end"}, bus0.dut_x, 32'hF);
    check({tag, "_busy_end"}, bus0.busy, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, bus0.done, 32'd0);
    check({tag, "_pass_hold"}, bus0.pass, exp_pass);
  endtask

  typedef struct {
    string       name;
    int          mode;     // 0 zero response, 1 benchmark circuit, 2 random table
    logic [15:0] gmask;    // golden_sig = model signature ^ gmask
    logic        exp_pass;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [15:0] exp_sig;
    int n, dcnt, d1, d2, k;
    bit got;

    tbl[0] = '{"zero_pass",  0, 16'h0000, 1'b1};
    tbl[1] = '{"zero_fail",  0, 16'h0001, 1'b0};
    tbl[2] = '{"circ_pass",  1, 16'h0000, 1'b1};
    tbl[3] = '{"circ_fail",  1, 16'h8000, 1'b0};
    tbl[4] = '{"rand_pass",  2, 16'h0000, 1'b1};
    tbl[5] = '{"rand_fail",  2, 16'h0100, 1'b0};

    bus0.start = 0; bus0.abort = 0; bus0.golden_sig = '0;
    bus1.start = 0; bus1.abort = 0; bus1.golden_sig = '0;
    for (int i = 0; i < 16; i++) begin
      lut0[i] = '0;
      lut1[i] = circ(i);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_x", bus0.dut_x, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_pass_fail", {bus0.pass, bus0.fail}, 0);
    check("rst_sig", bus0.signature, 0);
    check("rst_vc", bus0.vec_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven sweeps
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++)
        lut0[i] = (tbl[t].mode == 0) ? 5'd0 :
                  (tbl[t].mode == 1) ? circ(i) : 5'($urandom_range(0, 31));
      exp_sig = model_sig(lut0, 16);
      run_sweep(tbl[t].name, exp_sig ^ tbl[t].gmask, exp_sig, tbl[t].exp_pass);
    end

    // Randomized sweeps
    for (int r = 0; r < 4; r++) begin
      logic [15:0] m;
      for (int i = 0; i < 16; i++) lut0[i] = 5'($urandom_range(0, 31));
      exp_sig = model_sig(lut0, 16);
      m = ($urandom_range(0, 1) == 1) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      run_sweep("rnd", exp_sig ^ m, exp_sig, m == 16'h0);
    end

    // Abort while idle clears the last result and keeps the signature
    for (int i = 0; i < 16; i++) lut0[i] = circ(i);
    exp_sig = model_sig(lut0, 16);
    run_sweep("pre_abort", exp_sig, exp_sig, 1'b1);
    bus0.abort = 1'b1;
    @(posedge clk); #1;
    bus0.abort = 1'b0;
    check("idle_abort_pass", bus0.pass, 0);
    check("idle_abort_fail", bus0.fail, 0);
    check("idle_abort_sig", bus0.signature, exp_sig);

    // Abort mid-sweep at cycle 10
    bus0.start = 1'b1;
    for (n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      bus0.start = 1'b0;
    end
    bus0.abort = 1'b1;
    @(posedge clk); #1;
    bus0.abort = 1'b0;
    check("abort_busy", bus0.busy, 0);
    check("abort_done", bus0.done, 0);
    check("abort_x", bus0.dut_x, 0);
    check("abort_pass_fail", {bus0.pass, bus0.fail}, 0);
    check("abort_vc", bus0.vec_count, 4);
    check("abort_sig", bus0.signature, model_sig(lut0, 4));
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus0.done || bus0.busy) dcnt++;
    end
    check("abort_quiet", dcnt, 0);
    run_sweep("restart", exp_sig, exp_sig, 1'b1);

    // start held high: back-to-back sweeps
    bus0.start = 1'b1;
    dcnt = 0; d1 = 0; d2 = 0;
    for (n = 1; n <= 66; n++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        dcnt++;
        if (dcnt == 1) d1 = n - 1;
        else d2 = n - 1;
        if (bus0.pass !== 1'b1) dcnt = dcnt + 100;
      end
    end
    bus0.start = 1'b0;
    check("b2b_done_count", dcnt, 2);
    check("b2b_first", d1, 32);
    check("b2b_second", d2, 65);
    @(posedge clk); #1;
    check("b2b_idle", bus0.busy, 0);

    // Reset asserted mid-sweep
    bus0.start = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      bus0.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mrst_x", bus0.dut_x, 0);
    check("mrst_busy", bus0.busy, 0);
    check("mrst_sig", bus0.signature, 0);
    check("mrst_vc", bus0.vec_count, 0);
    check("mrst_pass_fail_done", {bus0.pass, bus0.fail, bus0.done}, 0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus0.done || bus0.busy) dcnt++;
    end
    check("mrst_quiet", dcnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SETTLE_CYC=3 instance: done 64 cycles after accept
    exp_sig = model_sig(lut1, 16);
    bus1.golden_sig = exp_sig;
    bus1.start = 1'b1;
    n = 0; got = 0; k = 0;
    while (n < 300 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) bus1.start = 1'b0;
      if (bus1.done) got = 1;
      else if (int'(bus1.dut_x) != (n - 1) / 4) k++;
    end
    check("s3_done_seen", 32'(got), 1);
    check("s3_latency", n - 1, 64);
    check("s3_walk", k, 0);
    check("s3_sig", bus1.signature, exp_sig);
    check("s3_pass", {bus1.pass, bus1.fail}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
